// File: rtl/traffic_intersection_ctrl_if.sv
// Signal bundle between the intersection controller and its surroundings:
// timebase strobe and request inputs in, lamp drives and status out.
interface traffic_intersection_ctrl_if;
  logic       tick;
  logic       ew_sensor;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ped_walk;
  logic       ped_wait;
  logic [2:0] phase;

  modport master (
    output tick, ew_sensor, ped_req,
    input  ns_light, ew_light, ped_walk, ped_wait, phase
  );

  modport slave (
    input  tick, ew_sensor, ped_req,
    output ns_light, ew_light, ped_walk, ped_wait, phase
  );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller: NS main road, EW side road, pedestrian
// walk phase. Timed phases are paced by the tick strobe; lamps are decoded
// from the state register only.
module traffic_intersection_ctrl #(
  parameter int NS_MIN   = 8,
  parameter int EW_GREEN = 6,
  parameter int YELLOW   = 3,
  parameter int ALLRED   = 2,
  parameter int PED      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  traffic_intersection_ctrl_if.slave   bus
);

  localparam logic [2:0] S_NSG  = 3'd0;
  localparam logic [2:0] S_NSY  = 3'd1;
  localparam logic [2:0] S_AR1  = 3'd2;
  localparam logic [2:0] S_EWG  = 3'd3;
  localparam logic [2:0] S_EWY  = 3'd4;
  localparam logic [2:0] S_AR2  = 3'd5;
  localparam logic [2:0] S_PEDW = 3'd6;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_GREEN  = 3'b010;
  localparam logic [2:0] L_YELLOW = 3'b001;

  // Last counter value of each timed phase (duration minus one).
  localparam logic [7:0] NS_LAST  = 8'(NS_MIN - 1);
  localparam logic [7:0] EWG_LAST = 8'(EW_GREEN - 1);
  localparam logic [7:0] Y_LAST   = 8'(YELLOW - 1);
  localparam logic [7:0] AR_LAST  = 8'(ALLRED - 1);
  localparam logic [7:0] PED_LAST = 8'(PED - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ew_pend_q, ew_pend_d;
  logic       ped_pend_q, ped_pend_d;

  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ped_walk;

  // Next-state selection: each timed phase leaves on the tick that ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NSG: begin
        if (bus.tick && (cnt_q >= NS_LAST) && (ew_pend_q || ped_pend_q)) state_d = S_NSY;
        else state_d = S_NSG;
      end
      S_NSY: begin
        if (bus.tick && (cnt_q == Y_LAST)) state_d = S_AR1;
        else state_d = S_NSY;
      end
      S_AR1: begin
        // Pedestrians are served ahead of a waiting EW car.
        if (bus.tick && (cnt_q == AR_LAST)) state_d = ped_pend_q ? S_PEDW : S_EWG;
        else state_d = S_AR1;
      end
      S_EWG: begin
        if (bus.tick && (cnt_q == EWG_LAST)) state_d = S_EWY;
        else state_d = S_EWG;
      end
      S_EWY: begin
        if (bus.tick && (cnt_q == Y_LAST)) state_d = S_AR2;
        else state_d = S_EWY;
      end
      S_AR2: begin
        if (bus.tick && (cnt_q == AR_LAST)) state_d = S_NSG;
        else state_d = S_AR2;
      end
      S_PEDW: begin
        // Both heads are already red, so EW green may follow without clearance.
        if (bus.tick && (cnt_q == PED_LAST)) state_d = ew_pend_q ? S_EWG : S_NSG;
        else state_d = S_PEDW;
      end
      default: state_d = S_AR2;
    endcase
  end

  // Phase tick counter: restarts on each state change, saturates in NS green.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (bus.tick) begin
      if (state_q == S_NSG) cnt_d = (cnt_q < NS_LAST) ? (cnt_q + 8'd1) : cnt_q;
      else cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Request latches: a single-cycle level registers; entering the served phase clears.
  always_comb begin
    ew_pend_d  = ew_pend_q;
    ped_pend_d = ped_pend_q;
    if ((state_d == S_EWG) && (state_q != S_EWG)) ew_pend_d = 1'b0;
    else if (bus.ew_sensor && (state_q != S_EWG)) ew_pend_d = 1'b1;
    else ew_pend_d = ew_pend_q;
    if ((state_d == S_PEDW) && (state_q != S_PEDW)) ped_pend_d = 1'b0;
    else if (bus.ped_req && (state_q != S_PEDW)) ped_pend_d = 1'b1;
    else ped_pend_d = ped_pend_q;
  end

  // State, counter and latch registers with synchronous reset into all-red.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_AR2;
      cnt_q      <= 8'd0;
      ew_pend_q  <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ew_pend_q  <= ew_pend_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  // Moore lamp decode; any unknown code shows red on both heads.
  always_comb begin
    ns_light = L_RED;
    ew_light = L_RED;
    ped_walk = 1'b0;
    case (state_q)
      S_NSG:   ns_light = L_GREEN;
      S_NSY:   ns_light = L_YELLOW;
      S_EWG:   ew_light = L_GREEN;
      S_EWY:   ew_light = L_YELLOW;
      S_PEDW:  ped_walk = 1'b1;
      default: begin
        ns_light = L_RED;
        ew_light = L_RED;
        ped_walk = 1'b0;
      end
    endcase
  end

  assign bus.ns_light = ns_light;
  assign bus.ew_light = ew_light;
  assign bus.ped_walk = ped_walk;
  assign bus.ped_wait = ped_pend_q;
  assign bus.phase    = state_q;

endmodule

// File: doc/traffic_intersection_ctrl.md
# traffic_intersection_ctrl

Two-road intersection controller that sequences a main road (NS) and a side road (EW) signal head, using the 3-bit one-hot light encoding of the existing single-head traffic signal. Pedestrian and side-road car requests are serviced with timed green, yellow and all-red clearance phases. A free-running timebase strobe (`tick`) paces the block. It sits between the sensor and push-button inputs and the lamp drivers.

## Interface
- `NS_MIN` , 8 : minimum NS green, in ticks (1–255)
- `EW_GREEN` , 6 : EW green duration, in ticks (1–255)
- `YELLOW` , 3 : yellow duration for either road, in ticks (1–255)
- `ALLRED` , 2 : all-red clearance duration, in ticks (1–255)
- `PED` , 5 : pedestrian walk duration, in ticks (1–255)
- `clk`  in  1  system clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `tick`  in  1  timebase strobe, one `clk` wide; may be held high (every cycle is a tick)
- `ew_sensor`  in  1  car waiting on the EW road; level, sampled every cycle
- `ped_req`  in  1  pedestrian button; level, sampled every cycle
- `ns_light`  out  3  NS head: RED=100, GREEN=010, YELLOW=001
- `ew_light`  out  3  EW head, same encoding
- `ped_walk`  out  1  walk lamp
- `ped_wait`  out  1  pedestrian request pending (the `ped_pend` latch)
- `phase`  out  3  current state code

## Operation
- Registers:
  - `state[2:0]`
  - `cnt[7:0]`: tick counter
  - `ew_pend`, `ped_pend`: request latches
- Counter behaviour:
  - `cnt` clears to 0 on every state change.
  - Otherwise `cnt` increments on `tick`.
  - In NSG, `cnt` saturates at `NS_MIN-1`.
- A state of duration N exits on the edge where `tick`=1 and `cnt`==N-1.
- States (code, lights NS/EW, walk, exit condition):
  - NSG (0), GREEN/RED: exits when `tick` & `cnt`>=`NS_MIN-1` & (`ew_pend`|`ped_pend`), going to NSY. With no request pending, it holds indefinitely.
  - NSY (1), YELLOW/RED: after `YELLOW` ticks, goes to AR1.
  - AR1 (2), RED/RED: after `ALLRED` ticks, goes to PEDW if `ped_pend`, otherwise to EWG.
  - EWG (3), RED/GREEN: after `EW_GREEN` ticks, goes to EWY.
  - EWY (4), RED/YELLOW: after `YELLOW` ticks, goes to AR2.
  - AR2 (5), RED/RED: after `ALLRED` ticks, goes to NSG.
  - PEDW (6), RED/RED, `ped_walk`=1: after `PED` ticks, goes to EWG if `ew_pend`, otherwise directly to NSG. No extra all-red is needed because both heads are already red.
  - Code 7 (illegal): both heads RED, walk 0. Goes to AR2 on the next edge unconditionally.
- `ew_pend` latch:
  - Set on any edge where `ew_sensor`=1 and the state is not EWG.
  - Cleared on the edge that enters EWG. Clear wins over a simultaneous set.
- `ped_pend` latch:
  - Set on any edge where `ped_req`=1 and the state is not PEDW.
  - Cleared on the edge that enters PEDW. Clear wins over a simultaneous set.
  - `ped_req` during PEDW is ignored.
- When both requests are pending at the end of AR1, the pedestrian phase is served first, then EWG.
- Light outputs, `ped_walk` and `phase` are decoded combinationally from `state` only (Moore).
- Safety: a GREEN or YELLOW on NS is never present together with a GREEN or YELLOW on EW. The walk lamp is never lit unless both heads are RED.

## Timing
- Reset state, all asserted on the first edge with `rst`=1:
  - `state`=AR2, `cnt`=0, `ew_pend`=`ped_pend`=0.
  - Outputs: `ns_light`=100, `ew_light`=100, `ped_walk`=0, `ped_wait`=0, `phase`=5.
- `rst` has priority over `tick` and over all requests.
- Reset mid-phase forces AR2 on the next edge. Any green or yellow drops to RED one cycle after `rst` is sampled.
- Transition latency: the output change is visible immediately after the deciding edge.
  - Example: with `tick` tied high, a state of N ticks lasts exactly N `clk` cycles.
- With `tick` every K cycles, a state of N ticks lasts between (N-1)·K+1 and N·K cycles.
  - The range arises because entry is not aligned to `tick`.
- A request arriving after NS has already been green for at least `NS_MIN` ticks causes NSY at the next tick.
- A request arriving earlier waits for `cnt` to reach `NS_MIN-1` and a tick to occur.
- A one-cycle pulse on `ew_sensor` or `ped_req` is sufficient to register a request.

## Test plan
All scenarios use default parameters and `tick` tied high unless stated.

- **Reset release:** deassert `rst` → `phase`=5 for 2 cycles, then NSG (`ns_light`=010, `ew_light`=100). With no requests, NSG holds for 100 cycles.
- **EW service:** pulse `ew_sensor` 1 cycle at NSG cycle 2.
  - Required sequence: NSG totals 8 cycles, NSY 3, AR1 2, EWG 6, EWY 3, AR2 2, then NSG.
  - `ew_pend` must be clear during EWG.
- **Pedestrian service:** pulse `ped_req` during NSG.
  - `ped_wait`=1 until PEDW.
  - Sequence: NSY 3, AR1 2, PEDW 5 (`ped_walk`=1, both heads 100), then NSG directly.
- **Both requests:** `ped_req` and `ew_sensor` high in the same NSG cycle → AR1, then PEDW 5, then EWG 6, EWY, AR2, NSG. Both latches must end at 0.
- **Reset mid-EWG:** assert `rst` for 1 cycle at EWG cycle 3.
  - Next cycle: `phase`=5, `ew_light`=100, latches 0.
  - Then AR2 lasts 2 cycles, then NSG.
- **Tick gating:** `tick` every 4 cycles, `ew_sensor` held high from reset → every NSY phase lasts 9–12 cycles. Throughout the run, the mutual-exclusion safety assertion holds on every cycle.
